// File: rtl/checker9_resp_misr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : checker9_resp_misr                                            |
// | Purpose  : Response-compaction stage for the checker9 FSM. Compacts       |
// |            WINDOW samples of the WIDTH-bit output word into a Galois      |
// |            MISR signature, counts non-zero samples (saturating) and       |
// |            compares the final signature against a golden value.          |
// | Ports    : clk      - clock, all state changes on posedge                 |
// |            rst      - asynchronous reset, active low                      |
// |            start    - pulse, begins a run from IDLE or DONE               |
// |            abort    - return to IDLE from any state (beats start)         |
// |            y_in     - response word, bit0 = y1                            |
// |            exp_sig  - golden signature, latched into pass on DONE entry   |
// |            busy     - high while capturing                                |
// |            done     - high once WINDOW samples have been compacted        |
// |            pass     - signature matched exp_sig (valid only with done)    |
// |            sig_out  - current signature register                          |
// |            nz_cnt   - saturating count of sampled non-zero words          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module checker9_resp_misr #(
  parameter int               WIDTH  = 11,
  parameter int               WINDOW = 16,
  parameter logic [WIDTH-1:0] POLY   = 11'h005,
  parameter logic [WIDTH-1:0] SEED   = 11'h000,
  parameter int               CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig_out,
  output logic [CNT_W-1:0] nz_cnt
);

  // Sample counter is sized to hold WINDOW so it never wraps inside a run.
  localparam int                SCNT_W = $clog2(WINDOW + 1);
  localparam logic [SCNT_W-1:0] C_LAST = SCNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_sig;
  logic [WIDTH-1:0]   w_sig_step;
  logic [CNT_W-1:0]   r_nz;
  logic [SCNT_W-1:0]  r_scnt;
  logic               r_pass;
  logic               w_last;

  // Galois MISR step: shift left, fold taps back in when the MSB leaves,
  // then absorb the response word.
  always_comb begin
    w_sig_step = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ y_in;
  end

  assign w_last = (r_scnt == C_LAST);

  // Next-state logic. start is only honoured outside CAPTURE so a stray
  // pulse cannot restart a run in progress.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start)  w_state_next = S_CAPTURE;
        S_CAPTURE:      if (w_last) w_state_next = S_DONE;
        default:        w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_nz    <= '0;
      r_scnt  <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (abort) begin
        r_sig  <= SEED;
        r_nz   <= '0;
        r_scnt <= '0;
        r_pass <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
        // y_in is only looked at here, so unknown values outside a run
        // never reach the state.
        r_sig  <= w_sig_step;
        r_scnt <= r_scnt + SCNT_W'(1);
        if ((|y_in) && !(&r_nz)) begin
          r_nz <= r_nz + CNT_W'(1);
        end
        // Verdict is frozen at DONE entry; later exp_sig changes are ignored.
        if (w_last) begin
          r_pass <= (w_sig_step == exp_sig);
        end
      end else if (start) begin
        r_sig  <= SEED;
        r_nz   <= '0;
        r_scnt <= '0;
        r_pass <= 1'b0;
      end
    end
  end

  assign busy    = (r_state == S_CAPTURE);
  assign done    = (r_state == S_DONE);
  assign pass    = r_pass & done;
  assign sig_out = r_sig;
  assign nz_cnt  = r_nz;

endmodule
`default_nettype wire

// File: tb/tb_checker9_resp_misr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_checker9_resp_misr                                         |
// | Purpose  : Directed self-checking bench for checker9_resp_misr. Instance  |
// |            A uses WINDOW=4, instance B uses WINDOW=10 with a 3-bit        |
// |            counter to exercise saturation. Expected signatures come from  |
// |            a bench-side MISR model queued when each run is launched.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_checker9_resp_misr;

  typedef struct {
    logic [10:0] sig;
    logic [7:0]  nz;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, start_b, abort_b;
  logic [10:0] y_a, y_b, exp_a, exp_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [10:0] sig_a, sig_b;
  logic [7:0]  nz_a;
  logic [2:0]  nz_b;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  checker9_resp_misr #(.WIDTH(11), .WINDOW(4), .POLY(11'h005), .SEED(11'h000), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .y_in(y_a), .exp_sig(exp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .sig_out(sig_a), .nz_cnt(nz_a));

  checker9_resp_misr #(.WIDTH(11), .WINDOW(10), .POLY(11'h005), .SEED(11'h000), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .y_in(y_b), .exp_sig(exp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .sig_out(sig_b), .nz_cnt(nz_b));

  function automatic logic [10:0] misr_step(input logic [10:0] s, input logic [10:0] y);
    logic [10:0] t;
    t = {s[9:0], 1'b0};
    if (s[10]) t = t ^ 11'h005;
    return t ^ y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [10:0] sig, input logic [7:0] nz,
                         input logic ps, output logic exp_pass);
    exp_t e;
    exp_pass = 1'b0;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      exp_pass = e.pass;
      chk({tag, "_sig"},  {21'd0, sig}, {21'd0, e.sig});
      chk({tag, "_nz"},   {24'd0, nz},  {24'd0, e.nz});
      chk({tag, "_pass"}, {31'd0, ps},  {31'd0, e.pass});
    end
  endtask

  // One WINDOW=4 run on instance A, launched at a negedge. restart_at picks a
  // sample during which start is pulsed again (negative for none).
  task automatic run_a(input string tag, input logic [3:0][10:0] ys,
                       input logic [10:0] expsig, input int restart_at);
    logic [10:0] s;
    logic [7:0]  n;
    logic        ep;
    exp_t        e;
    s = 11'h000;
    n = 8'd0;
    for (int i = 0; i < 4; i++) begin
      s = misr_step(s, ys[i]);
      if (ys[i] != 11'h000 && n != 8'hff) n++;
    end
    e.sig = s; e.nz = n; e.pass = (s == expsig);
    sb.push_back(e);
    exp_a   = expsig;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      y_a     = ys[i];
      start_a = (i == restart_at);
      @(negedge clk);
      start_a = 1'b0;
      chk({tag, (i == 3) ? "_done_window" : "_done_early"}, {31'd0, done_a}, (i == 3) ? 32'd1 : 32'd0);
    end
    y_a = 'x;
    pop_cmp(tag, sig_a, nz_a, pass_a, ep);
    // Verdict must not follow exp_sig after DONE is reached.
    exp_a = ~expsig;
    @(negedge clk);
    chk({tag, "_pass_hold"}, {31'd0, pass_a}, {31'd0, ep});
  endtask

  initial begin
    int          busy_cycles;
    int          done_at;
    logic [10:0] s;
    logic        ep;
    exp_t        e;

    rst = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    y_a = 'x; y_b = 'x; exp_a = 11'h000; exp_b = 11'h000;
    @(negedge clk);
    chk("rst_sig",  {21'd0, sig_a}, 32'h0);
    chk("rst_nz",   {24'd0, nz_a},  32'h0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_pass", {31'd0, pass_a}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_sig_xin", {21'd0, sig_a}, 32'h0);

    run_a("zero",  {11'h000, 11'h000, 11'h000, 11'h000}, 11'h000, -1);
    run_a("lsb",   {11'h000, 11'h000, 11'h000, 11'h001}, 11'h010, -1);
    run_a("msb",   {11'h000, 11'h000, 11'h000, 11'h400}, 11'h014, -1);
    run_a("msb2",  {11'h000, 11'h000, 11'h000, 11'h400}, 11'h014, -1);
    run_a("mixed", {11'h7ff, 11'h000, 11'h2a5, 11'h513}, 11'h123, -1);
    run_a("restart", {11'h0f0, 11'h00f, 11'h400, 11'h0c1}, 11'h000, 1);

    // abort and start together on the second sample
    exp_a = 11'h000; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; y_a = 11'h155;
    @(negedge clk);
    abort_a = 1'b1; start_a = 1'b1; y_a = 11'h2aa;
    @(negedge clk);
    abort_a = 1'b0; start_a = 1'b0; y_a = 'x;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_sig",  {21'd0, sig_a},  32'h0);
    chk("abort_nz",   {24'd0, nz_a},   32'h0);
    chk("abort_pass", {31'd0, pass_a}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", {31'd0, done_a}, 32'd0);

    // asynchronous reset between edges in the middle of a run
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; y_a = 11'h123;
    @(negedge clk);
    s = misr_step(11'h000, 11'h123);
    chk("midrun_sig", {21'd0, sig_a}, {21'd0, s});
    #2 rst = 1'b0;
    #1;
    chk("async_sig",  {21'd0, sig_a},  32'h0);
    chk("async_nz",   {24'd0, nz_a},   32'h0);
    chk("async_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_no_done", {31'd0, done_a}, 32'd0);
    chk("post_rst_no_busy", {31'd0, busy_a}, 32'd0);
    run_a("after_rst", {11'h000, 11'h000, 11'h000, 11'h001}, 11'h008, -1);

    // WINDOW=10, 3-bit counter: saturation and exact capture length
    s = 11'h000;
    for (int i = 0; i < 10; i++) s = misr_step(s, 11'h040);
    e.sig = s; e.nz = 8'd7; e.pass = 1'b1;
    sb.push_back(e);
    exp_b = s; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; y_b = 11'h040;
    busy_cycles = 0;
    done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (busy_b) busy_cycles++;
      if (done_b && done_at < 0) done_at = c;
      @(negedge clk);
    end
    y_b = 'x;
    chk("b_busy_cycles", busy_cycles, 32'd10);
    chk("b_done_at", done_at, 32'd10);
    pop_cmp("b", sig_b, {5'd0, nz_b}, pass_b, ep);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/checker9_resp_misr.md
Name: checker9_resp_misr

Overview:
- Downstream response-compaction stage for the checker9 FSM.
- Consumes the 11-bit output word y11..y1 over a programmable window of clock cycles and compacts it into an 11-bit Galois MISR signature.
- Also counts active (non-zero) cycles and compares the final signature against an expected value.
- Used by the lock/trojan evaluation harness to tell correct-key runs from wrong-key or trojan-triggered runs without storing full traces.

Parameters:
- WIDTH, 11, response word width; must equal the checker output count.
- WINDOW, 16, number of samples compacted per run; legal range 1..255.
- POLY, 11'h005, MISR feedback taps (x^11+x^2+1), applied when the MSB shifts out.
- SEED, 11'h000, signature value loaded when a run starts.
- CNT_W, 8, width of the non-zero cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge. The checker updates on negedge, so y_in is stable half a cycle before sampling.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- y_in  in  WIDTH  response word; bit0=y1 ... bit10=y11.
- exp_sig  in  WIDTH  golden signature; compared only in DONE.
- busy  out  1  high in CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  in DONE: (sig_out==exp_sig), registered on entry to DONE. 0 elsewhere.
- sig_out  out  WIDTH  current signature register.
- nz_cnt  out  CNT_W  count of sampled cycles with y_in!=0; saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; sig_out=SEED; nz_cnt=0; busy=0, done=0, pass=0; internal sample counter=0.
- States are IDLE, CAPTURE, DONE, all registered; outputs busy, done and pass decode directly from state/registers.
- IDLE:
  - start=1 at posedge k → CAPTURE; sig_out←SEED; nz_cnt←0; sample counter←0.
  - Otherwise hold.
- CAPTURE:
  - Each posedge: sig_out ← ({sig[9:0],1'b0} ^ (sig[10] ? POLY : 0)) ^ y_in.
  - nz_cnt ← nz_cnt+1 if y_in!=0 and nz_cnt is not all-ones; otherwise hold.
  - Sample counter increments each posedge.
  - On the posedge where the counter equals WINDOW-1 (the WINDOW-th sample), the final update is taken and state → DONE.
- Latency: start at posedge k → samples at posedges k+1..k+WINDOW → done=1 after posedge k+WINDOW.
- start during CAPTURE is ignored and does not restart the run.
- DONE:
  - sig_out and nz_cnt hold.
  - pass is registered on the transition into DONE using the exp_sig value at that edge. It is not recomputed if exp_sig changes later.
  - start → new run exactly as from IDLE (done drops the next cycle).
  - Otherwise stay in DONE indefinitely.
- abort=1 at any posedge: state→IDLE, sig_out←SEED, nz_cnt←0, pass←0. abort has priority over start in the same cycle.
- Reset mid-run: immediate asynchronous return to the reset values. A partial signature is never reported as done.
- No X propagation: y_in is sampled only in CAPTURE, and an unknown y_in outside CAPTURE must not affect the outputs.
- Arithmetic: all MISR operations are bitwise at WIDTH bits. The sample counter is $clog2(WINDOW+1) bits and never wraps within a run.

Test Plan:
- WINDOW=4; reset, start, y_in=0 for 4 cycles → done=1 after the 4th sample edge; sig_out=11'h000; nz_cnt=0; pass=1 with exp_sig=0.
- WINDOW=4; start, y_in=11'h001 for 1 sample then 0 for 3 → sig_out=11'h008; nz_cnt=1; pass=0 with exp_sig=11'h010.
- WINDOW=4; start, y_in=11'h400 then 0,0,0 → sig sequence 400, 005, 00A, 014; final sig_out=11'h014; nz_cnt=1.
- CNT_W=3, WINDOW=10; y_in=11'h040 every cycle → nz_cnt saturates at 7; done after exactly 10 samples; busy high for exactly 10 cycles.
- WINDOW=4:
  - start pulse again mid-CAPTURE → ignored; done at the original cycle.
  - abort and start together on sample 2 → IDLE, sig_out=SEED, nz_cnt=0.
  - Second run from DONE via start → fresh signature identical to the first run for identical stimulus.
- Drive rst=0 asynchronously mid-CAPTURE (between clock edges) → outputs go to reset values immediately; after release, no done until a new start plus WINDOW samples.
